// File: rtl/spi_flash_resp.sv
// Serial-flash responder: target side of a single-lane SPI mode-0 link.
// Serves READ (0x03) from a synchronous byte memory, RDID (0x9F) and RDSR (0x05).
// All pad inputs are oversampled in the clk domain; outputs are registered.
module spi_flash_resp #(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018,
    parameter logic [7:0]  STATUS   = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_dq0,
    output logic              spi_dq1_o,
    output logic              spi_dq1_oe,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    // Shift register only needs to hold the low address bits (plus the opcode).
    localparam int unsigned SR_W = ADDR_W - 1;

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StIgnore} state_e;
    typedef enum logic [1:0] {SrcMem, SrcId, SrcStat} src_e;

    logic cs_meta, cs_s, sck_meta, sck_s, sck_prev, dq_meta, dq_s;
    logic sck_rise, sck_fall;

    state_e            state_q, state_d;
    src_e              src_q, src_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        nxt_q, nxt_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              rd_pend_q, rd_pend_d;
    logic              dq1_q, dq1_d;
    logic              oe_q, oe_d;
    logic              cmd_err_q, cmd_err_d;
    logic [1:0]        id_next;

    // Two-flop synchronizers plus previous sck for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta  <= 1'b1;
            cs_s     <= 1'b1;
            sck_meta <= 1'b0;
            sck_s    <= 1'b0;
            sck_prev <= 1'b0;
            dq_meta  <= 1'b0;
            dq_s     <= 1'b0;
        end else begin
            cs_meta  <= spi_cs_n;
            cs_s     <= cs_meta;
            sck_meta <= spi_sck;
            sck_s    <= sck_meta;
            sck_prev <= sck_s;
            dq_meta  <= spi_dq0;
            dq_s     <= dq_meta;
        end
    end

    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign id_next  = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            src_q      <= SrcMem;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            addr_q     <= '0;
            tx_q       <= '0;
            nxt_q      <= '0;
            id_idx_q   <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            rd_pend_q  <= 1'b0;
            dq1_q      <= 1'b0;
            oe_q       <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            nxt_q      <= nxt_d;
            id_idx_q   <= id_idx_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rd_pend_q  <= rd_pend_d;
            dq1_q      <= dq1_d;
            oe_q       <= oe_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    // Next-state: command decode, address shift, byte streaming.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        nxt_d      = nxt_q;
        id_idx_d   = id_idx_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        rd_pend_d  = mem_req_q;
        dq1_d      = dq1_q;
        oe_d       = oe_q;
        cmd_err_d  = 1'b0;

        if (cs_s) begin
            // Deselect discards everything, including an in-flight read.
            state_d   = StIdle;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            rd_pend_d = 1'b0;
        end else begin
            // nxt holds the byte to be shifted out at the next byte boundary.
            if (rd_pend_q) nxt_d = mem_rdata;
            unique case (state_q)
                StIdle: begin
                    state_d   = StCmd;
                    bit_cnt_d = '0;
                end
                StCmd: begin
                    if (sck_rise) begin
                        sr_d      = {sr_q[SR_W-2:0], dq_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            case ({sr_q[6:0], dq_s})
                                8'h03: state_d = StAddr;
                                8'h9F: begin
                                    state_d  = StData;
                                    src_d    = SrcId;
                                    nxt_d    = JEDEC_ID[23:16];
                                    id_idx_d = 2'd0;
                                end
                                8'h05: begin
                                    state_d = StData;
                                    src_d   = SrcStat;
                                    nxt_d   = STATUS;
                                end
                                default: begin
                                    state_d   = StIgnore;
                                    cmd_err_d = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                StAddr: begin
                    if (sck_rise) begin
                        sr_d      = {sr_q[SR_W-2:0], dq_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d  = '0;
                            addr_d     = {sr_q, dq_s};
                            mem_req_d  = 1'b1;
                            mem_addr_d = {sr_q, dq_s};
                            state_d    = StData;
                            src_d      = SrcMem;
                        end
                    end
                end
                StData: begin
                    if (sck_rise) begin
                        bit_cnt_d = (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
                    end
                    if (sck_fall) begin
                        oe_d = 1'b1;
                        if (bit_cnt_q == 5'd0) begin
                            // Byte boundary: start next byte and refill nxt.
                            dq1_d = nxt_q[7];
                            tx_d  = {nxt_q[6:0], 1'b0};
                            unique case (src_q)
                                SrcMem: begin
                                    addr_d     = addr_q + ADDR_W'(1);
                                    mem_req_d  = 1'b1;
                                    mem_addr_d = addr_q + ADDR_W'(1);
                                end
                                SrcId: begin
                                    id_idx_d = id_next;
                                    unique case (id_next)
                                        2'd0:    nxt_d = JEDEC_ID[23:16];
                                        2'd1:    nxt_d = JEDEC_ID[15:8];
                                        default: nxt_d = JEDEC_ID[7:0];
                                    endcase
                                end
                                default: nxt_d = STATUS;
                            endcase
                        end else begin
                            dq1_d = tx_q[7];
                            tx_d  = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi_dq1_o  = dq1_q;
    assign spi_dq1_oe = oe_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign busy       = ~cs_s;
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_resp.sv
// Scoreboard bench for spi_flash_resp: an SPI initiator drives random frames,
// expectations go into queues, monitors pop and compare as the DUT responds.
module tb_spi_flash_resp;

    localparam int H = 6;  // sck half period in clk cycles
    localparam logic [23:0] JEDEC = 24'hEF4018;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_dq0 = 1'b0;
    logic        spi_dq1_o, spi_dq1_oe, mem_req, busy, cmd_err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mem [0:65535];

    int vectors = 0;
    int errors = 0;
    int exp_err = 0;
    int got_err = 0;
    logic [15:0] exp_addr_q[$];
    logic [7:0]  exp_byte_q[$];

    spi_flash_resp #(.ADDR_W(16), .JEDEC_ID(JEDEC), .STATUS(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_cs_n  (spi_cs_n),
        .spi_sck   (spi_sck),
        .spi_dq0   (spi_dq0),
        .spi_dq1_o (spi_dq1_o),
        .spi_dq1_oe(spi_dq1_oe),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM image.
    always @(posedge clk) if (mem_req) mem_rdata <= mem[mem_addr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Memory request monitor.
    always @(negedge clk) begin
        if (rst_n && mem_req) begin
            check("mem_req expected", 32'(exp_addr_q.size() > 0), 32'd1);
            if (exp_addr_q.size() > 0) check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
        end
        if (rst_n && cmd_err) got_err++;
    end

    // MISO monitor: the initiator samples on sck rise.
    int nb = 0;
    logic [7:0] cur = 8'h00;
    always @(posedge spi_sck or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            nb = 0;
        end else if (spi_dq1_oe) begin
            cur = {cur[6:0], spi_dq1_o};
            nb++;
            if (nb == 8) begin
                nb = 0;
                check("miso byte expected", 32'(exp_byte_q.size() > 0), 32'd1);
                if (exp_byte_q.size() > 0) check("miso byte", 32'(cur), 32'(exp_byte_q.pop_front()));
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic b);
        spi_dq0 = b;
        wait_clk(H);
        spi_sck = 1'b1;
        wait_clk(H);
        spi_sck = 1'b0;
    endtask

    task automatic send(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bit_out(v[i]);
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) bit_out(1'($urandom_range(1, 0)));
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        wait_clk(H);
        check("busy in frame", 32'(busy), 32'd1);
    endtask

    task automatic cs_end();
        wait_clk(H);
        spi_cs_n = 1'b1;
        wait_clk(2 * H);
        check("busy idle / oe off", {30'd0, busy, spi_dq1_oe}, 32'd0);
    endtask

    // Reference model: READ of n bytes at a returns mem[a..a+n-1] (mod 2^16);
    // a request goes out at a, then one prefetch per byte boundary.
    task automatic do_read(input logic [23:0] a, input int n);
        logic [15:0] base;
        base = a[15:0];
        for (int i = 0; i < n + 2; i++) exp_addr_q.push_back(base + 16'(i));
        for (int i = 0; i < n; i++) exp_byte_q.push_back(mem[base + 16'(i)]);
        cs_begin();
        send(32'h03, 8);
        send(32'(a), 24);
        send_rand(8 * n);
        cs_end();
    endtask

    task automatic do_rdid(input int n);
        logic [23:0] id;
        id = JEDEC;
        for (int i = 0; i < n; i++) begin
            case (i % 3)
                0:       exp_byte_q.push_back(id[23:16]);
                1:       exp_byte_q.push_back(id[15:8]);
                default: exp_byte_q.push_back(id[7:0]);
            endcase
        end
        cs_begin();
        send(32'h9F, 8);
        send_rand(8 * n);
        cs_end();
    endtask

    task automatic do_rdsr(input int n);
        for (int i = 0; i < n; i++) exp_byte_q.push_back(8'h00);
        cs_begin();
        send(32'h05, 8);
        send_rand(8 * n);
        cs_end();
    endtask

    task automatic do_bad(input logic [7:0] op, input int nbits);
        exp_err++;
        cs_begin();
        send(32'(op), 8);
        for (int i = 0; i < nbits; i++) begin
            bit_out(1'($urandom_range(1, 0)));
            wait_clk(H / 2);
            check("ignore oe", 32'(spi_dq1_oe), 32'd0);
        end
        cs_end();
        check("cmd_err count", 32'(got_err), 32'(exp_err));
    endtask

    task automatic do_abort(input logic [23:0] a, input int k);
        cs_begin();
        send(32'h03, 8);
        send(32'(a >> (24 - k)), k);
        cs_end();
    endtask

    initial begin
        logic [7:0] op;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0010] = 8'hA5;
        mem[16'h0011] = 8'h3C;

        wait_clk(3);
        check("reset outputs", {11'd0, spi_dq1_o, spi_dq1_oe, mem_req, mem_addr, busy, cmd_err},
              32'd0);
        rst_n = 1'b1;
        wait_clk(4);

        // Reset asserted in the middle of an address phase.
        cs_begin();
        send(32'h03, 8);
        send(32'h12, 10);
        rst_n = 1'b0;
        wait_clk(2);
        check("reset mid-frame", {11'd0, spi_dq1_o, spi_dq1_oe, mem_req, mem_addr, busy, cmd_err},
              32'd0);
        spi_cs_n = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(2 * H);

        do_read(24'h000010, 2);
        do_read(24'h01FFFF, 2);
        do_rdid(4);
        do_rdsr(1);
        do_bad(8'hAB, 16);
        do_abort(24'h000ABC, 12);
        do_read(24'h000000, 1);
        do_bad(8'h6B, 8);
        do_bad(8'hEB, 8);

        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(5, 0))
                0, 1: do_read(24'($urandom), int'($urandom_range(4, 1)));
                2:    do_rdid(int'($urandom_range(5, 1)));
                3:    do_rdsr(int'($urandom_range(3, 1)));
                4: begin
                    do op = 8'($urandom);
                    while (op == 8'h03 || op == 8'h9F || op == 8'h05);
                    do_bad(op, int'($urandom_range(16, 1)));
                end
                default: do_abort(24'($urandom), int'($urandom_range(23, 0)));
            endcase
        end

        wait_clk(20);
        check("mem_req all seen", 32'(exp_addr_q.size()), 32'd0);
        check("miso all seen", 32'(exp_byte_q.size()), 32'd0);
        check("cmd_err total", 32'(got_err), 32'(exp_err));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_resp.md
Name: spi_flash_resp

Overview:
Serial-flash responder: the target end of the SoC's qspi0 initiator (cs, sck, dq[3:0]). It decodes single-lane SPI mode-0 commands and serves read data from a synchronous memory port (BRAM image). Used in FPGA bring-up and simulation in place of the physical flash, so XIP boot can run without the board flash part. All pad-side inputs are oversampled in the system clock domain.

Parameters:
ADDR_W, 16, width of memory byte address; the 24-bit SPI address is truncated to it, so reads wrap at 2^ADDR_W.
JEDEC_ID, 24'hEF4018, 3-byte ID returned by RDID (0x9F), MSB byte first.
STATUS, 8'h00, byte returned repeatedly by RDSR (0x05).

Ports:
clk  in  1  system clock; must be >= 10x the sck frequency.
rst_n  in  1  asynchronous active-low reset.
spi_cs_n  in  1  chip select from the initiator, active-low, asynchronous to clk.
spi_sck  in  1  serial clock from the initiator, asynchronous to clk.
spi_dq0  in  1  MOSI from the initiator.
spi_dq1_o  out  1  MISO value.
spi_dq1_oe  out  1  MISO output enable; pad is tristated when 0.
mem_req  out  1  single-cycle read strobe.
mem_addr  out  ADDR_W  read byte address; valid when mem_req=1.
mem_rdata  in  8  read data, valid exactly 1 clk after mem_req.
busy  out  1  1 while cs_n (synchronized) is low.
cmd_err  out  1  1-clk pulse when an unsupported opcode completes.

Behaviour:
- Reset values: spi_dq1_o=0, spi_dq1_oe=0, mem_req=0, mem_addr=0, busy=0, cmd_err=0. FSM goes to IDLE, all counters are 0.
- Synchronizers: cs_n, sck and dq0 each pass through a 2-FF synchronizer; sck rise/fall are 1-clk pulses from the synchronized value vs its previous value.
- SPI mode 0, MSB first. dq0 is sampled on sck rise. dq1 updates on sck fall.
- FSM states: IDLE, CMD, ADDR, DATA, IGNORE.
- IDLE: sync cs_n falling -> CMD, bit count=0.
- CMD: shift 8 bits. On the 8th rise:
  - 0x03 -> ADDR.
  - 0x9F -> DATA (ID source, 3-byte cycle).
  - 0x05 -> DATA (status source).
  - any other opcode -> IGNORE, and cmd_err pulses the next clk.
- ADDR: shift 24 bits.
  - On the 24th rise: mem_req=1 with mem_addr=addr[ADDR_W-1:0].
  - mem_rdata is captured into the tx register 1 clk later.
  - tx[7] is driven at the next sck fall, where spi_dq1_oe rises.
- DATA, memory source:
  - Each sck fall shifts the next tx bit onto spi_dq1_o.
  - At the fall that drives bit 7 of a byte, issue a prefetch: mem_req at addr+1 (mod 2^ADDR_W), result held in a 1-byte buffer.
  - At the fall following the 8th rise of a byte, load tx from the buffer and drive its bit 7. Streaming is gapless and unbounded.
- DATA, ID source: bytes JEDEC_ID[23:16], [15:8], [7:0], then repeat. No mem_req is issued.
- DATA, status source: STATUS repeated. No mem_req is issued.
- IGNORE: spi_dq1_oe stays 0; sck edges are ignored until cs_n rises.
- Sync cs_n high in any state:
  - The same clk returns to IDLE; spi_dq1_oe=0 on the next clk.
  - Partial bytes and counters are discarded.
  - A pending mem_rdata is dropped.
  - This covers termination mid-command, mid-address and mid-data.
- sck edges while cs_n is high are ignored.
- dq1..dq3 beyond MISO are never driven. Quad modes are out of scope; opcodes 0x6B and 0xEB give cmd_err.
- busy = synchronized cs_n inverted.
- If sck exceeds clk/10 the behaviour is undefined. No detection is required.

Test Plan:
- Reset: assert rst_n=0 mid-transfer -> all outputs 0 while low; after release, the first transaction starts cleanly from CMD.
- Read: preload mem[0x0010]=0xA5, [0x0011]=0x3C. Send 0x03, 0x000010, then clock 16 bits -> MISO reads 0xA5 then 0x3C; mem_req fires at 0x0010 then 0x0011.
- Wrap: ADDR_W=16, read from 0x01FFFF for 2 bytes -> mem_addr sequence 0xFFFF, 0x0000; data matches mem[0xFFFF], mem[0x0000].
- RDID: 0x9F then 32 clocks -> MISO reads EF 40 18 EF; mem_req never asserts.
- RDSR / bad opcode:
  - 0x05 then 8 clocks -> 0x00.
  - 0xAB -> cmd_err one pulse; spi_dq1_oe stays 0 for the rest of the frame.
- Abort: raise cs_n after 12 address bits; a new 0x03 read of 0x000000 -> correct mem[0] byte, with no leftover address bits.
